// File: rtl/sisc_exec_ctrl.sv
// Execute-stage datapath (ALU, status flags, branch target) and the multi-cycle
// control FSM of the SISC processor.
module sisc_exec_ctrl (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [15:0] pc_in,
  input  logic [3:0]  stat_q,
  output logic [31:0] alu_result,
  output logic [3:0]  stat_out,
  output logic        stat_en,
  output logic [15:0] br_addr,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        br_sel,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        rb_sel,
  output logic        ir_load,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_RESET, S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BRR  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BNR  = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_NOT = 4'h2;
  localparam logic [3:0] FN_AND = 4'h3;
  localparam logic [3:0] FN_OR  = 4'h4;
  localparam logic [3:0] FN_XOR = 4'h5;
  localparam logic [3:0] FN_SHL = 4'h6;
  localparam logic [3:0] FN_SHR = 4'h7;

  state_e state_q, state_d;

  logic [3:0]  opcode, mm, alu_fn;
  logic [15:0] imm;
  logic [31:0] op_b, alu_res;
  logic [32:0] sum_w, dif_w;
  logic        flag_c, flag_v;
  logic        is_alu, is_br, br_abs, br_inv, cond_hit, br_taken;
  logic        unused_fields;

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] == b[31]) && (r[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] r);
    return (a[31] != b[31]) && (r[31] != a[31]);
  endfunction

  assign opcode = instr[31:28];
  assign mm     = instr[27:24];
  assign imm    = instr[15:0];
  assign unused_fields = ^instr[23:16];

  assign is_alu   = (opcode == OP_ALU) || (opcode == OP_ADDI);
  assign is_br    = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                    (opcode == OP_BNE) || (opcode == OP_BNR);
  assign br_abs   = (opcode == OP_BRA) || (opcode == OP_BNE);
  assign br_inv   = (opcode == OP_BNE) || (opcode == OP_BNR);
  assign cond_hit = (mm == 4'h0) || ((mm & stat_q) != 4'h0);
  // The inverse forms complement the whole condition, so mm == 0 never branches.
  assign br_taken = is_br && (cond_hit ^ br_inv);

  // ADDI reuses the ADD path with a sign-extended immediate as operand B.
  assign op_b   = (opcode == OP_ADDI) ? {{16{imm[15]}}, imm} : rsb;
  assign alu_fn = (opcode == OP_ADDI) ? FN_ADD : instr[3:0];
  assign sum_w  = {1'b0, rsa} + {1'b0, op_b};
  assign dif_w  = {1'b0, rsa} + {1'b0, ~op_b} + 33'd1;

  always_comb begin
    alu_res = rsa;
    flag_c  = 1'b0;
    flag_v  = 1'b0;
    case (alu_fn)
      FN_ADD: begin
        alu_res = sum_w[31:0];
        flag_c  = sum_w[32];
        flag_v  = add_ovf(rsa, op_b, sum_w[31:0]);
      end
      FN_SUB: begin
        alu_res = dif_w[31:0];
        flag_c  = dif_w[32];
        flag_v  = sub_ovf(rsa, op_b, dif_w[31:0]);
      end
      FN_NOT:  alu_res = ~rsa;
      FN_AND:  alu_res = rsa & op_b;
      FN_OR:   alu_res = rsa | op_b;
      FN_XOR:  alu_res = rsa ^ op_b;
      FN_SHL:  alu_res = rsa << op_b[4:0];
      FN_SHR:  alu_res = rsa >> op_b[4:0];
      default: alu_res = rsa;
    endcase
  end

  assign alu_result = alu_res;
  assign stat_out   = {flag_c, alu_res[31], flag_v, (alu_res == 32'd0)};
  assign br_addr    = br_sel ? imm : (pc_in + imm);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     state_d = S_START;
      S_START:     state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RESET;
    endcase
  end

  always_comb begin
    stat_en  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    rb_sel   = 1'b0;
    ir_load  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_RESET, S_START: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_abs;
        end
      end
      S_EXECUTE:   stat_en = is_alu;
      S_WRITEBACK: rf_we   = is_alu;
      S_HALT:      halted  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Bench for sisc_exec_ctrl: table of instructions run through the FSM, with an
// ALU scoreboard popped on each stat_en pulse, plus reset/halt sequences.
module tb_sisc_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_f = 1'b1;
  logic [31:0] instr = 32'd0, rsa = 32'd0, rsb = 32'd0;
  logic [15:0] pc_in = 16'd0;
  logic [3:0]  stat_q = 4'd0;
  logic [31:0] alu_result;
  logic [3:0]  stat_out;
  logic [15:0] br_addr;
  logic stat_en, rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, rb_sel, ir_load, halted;

  sisc_exec_ctrl dut (
    .clk(clk), .rst_f(rst_f), .instr(instr), .rsa(rsa), .rsb(rsb),
    .pc_in(pc_in), .stat_q(stat_q), .alu_result(alu_result),
    .stat_out(stat_out), .stat_en(stat_en), .br_addr(br_addr),
    .rf_we(rf_we), .wb_sel(wb_sel), .br_sel(br_sel), .pc_rst(pc_rst),
    .pc_write(pc_write), .pc_sel(pc_sel), .rb_sel(rb_sel),
    .ir_load(ir_load), .halted(halted)
  );

  always #5 clk = ~clk;

  // Control vector: {halted, stat_en, rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, rb_sel, ir_load}
  localparam logic [9:0] C_NONE  = 10'h000;
  localparam logic [9:0] C_RST   = 10'h010;
  localparam logic [9:0] C_FETCH = 10'h009;
  localparam logic [9:0] C_BRABS = 10'h02C;
  localparam logic [9:0] C_BRREL = 10'h00C;
  localparam logic [9:0] C_STAT  = 10'h100;
  localparam logic [9:0] C_RFWE  = 10'h080;
  localparam logic [9:0] C_HALT  = 10'h200;

  typedef struct {
    logic [31:0] ins, a, b;
    logic [15:0] pc;
    logic [3:0]  sq;
    logic        alu;
    logic [31:0] res;
    logic [3:0]  st;
    logic [9:0]  dec;
    logic        chk_br;
    logic [15:0] br;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  st;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   stat_cnt = 0, we_cnt = 0;
  int   n_alu = 0;

  function automatic logic [9:0] ctl();
    return {halted, stat_en, rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, rb_sel, ir_load};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ialu(input logic [3:0] f);
    return {4'h1, 24'h0, f};
  endfunction

  function automatic logic [31:0] iaddi(input logic [15:0] im);
    return {4'h2, 12'h0, im};
  endfunction

  function automatic logic [31:0] ibr(input logic [3:0] op, input logic [3:0] m,
                                      input logic [15:0] im);
    return {op, m, 8'h00, im};
  endfunction

  function automatic vec_t alu_v(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res,
                                 input logic [3:0] st);
    vec_t v;
    v.ins = ins; v.a = a; v.b = b; v.pc = 16'h0; v.sq = 4'h0;
    v.alu = 1'b1; v.res = res; v.st = st; v.dec = C_NONE;
    v.chk_br = 1'b0; v.br = 16'h0;
    return v;
  endfunction

  function automatic vec_t br_v(input logic [31:0] ins, input logic [15:0] pc,
                                input logic [3:0] sq, input logic [9:0] dec,
                                input logic chk_br, input logic [15:0] br);
    vec_t v;
    v.ins = ins; v.a = 32'h0; v.b = 32'h0; v.pc = pc; v.sq = sq;
    v.alu = 1'b0; v.res = 32'h0; v.st = 4'h0; v.dec = dec;
    v.chk_br = chk_br; v.br = br;
    return v;
  endfunction

  // Scoreboard consumer: every stat_en pulse must match the oldest pending ALU op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_we) we_cnt++;
      if (stat_en) begin
        stat_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stat_en: got pulse, expected none (result %h)", alu_result);
        end else begin
          e = sb.pop_front();
          chk("alu_result", alu_result, e.res);
          chk("stat_out", 32'(stat_out), 32'(e.st));
        end
      end
    end
  end

  task automatic wait_fetch();
    int n;
    n = 0;
    while (ir_load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ir_load !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no FETCH in %0d cycles, expected one", n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    wait_fetch();
    chk($sformatf("v%0d_fetch", idx), 32'(ctl()), 32'(C_FETCH));
    instr = v.ins; rsa = v.a; rsb = v.b; pc_in = v.pc; stat_q = v.sq;
    if (v.alu) sb.push_back('{res: v.res, st: v.st});
    @(negedge clk);
    chk($sformatf("v%0d_decode", idx), 32'(ctl()), 32'(v.dec));
    if (v.chk_br) chk($sformatf("v%0d_br_addr", idx), 32'(br_addr), 32'(v.br));
    @(negedge clk);
    chk($sformatf("v%0d_execute", idx), 32'(ctl()), 32'(v.alu ? C_STAT : C_NONE));
    @(negedge clk);
    chk($sformatf("v%0d_mem", idx), 32'(ctl()), 32'(C_NONE));
    @(negedge clk);
    chk($sformatf("v%0d_writeback", idx), 32'(ctl()), 32'(v.alu ? C_RFWE : C_NONE));
  endtask

  // Releases rst_f between edges, then expects START and an immediate FETCH.
  task automatic reset_release(input string nm);
    @(negedge clk);
    #2 rst_f = 1'b1;
    @(negedge clk);
    chk({nm, "_start"}, 32'(ctl()), 32'(C_RST));
    @(negedge clk);
    chk({nm, "_fetch"}, 32'(ctl()), 32'(C_FETCH));
  endtask

  initial begin
    int s0, w0;

    vecs.push_back(alu_v(ialu(4'h0), 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b0110));
    vecs.push_back(alu_v(ialu(4'h1), 32'h5,         32'h5,         32'h0,         4'b1001));
    vecs.push_back(alu_v(iaddi(16'hFFFF), 32'h1,    32'hDEAD_BEEF, 32'h0,         4'b1001));
    vecs.push_back(alu_v(ialu(4'h1), 32'h3,         32'h5,         32'hFFFF_FFFE, 4'b0100));
    vecs.push_back(alu_v(ialu(4'h2), 32'h0000_FFFF, 32'h0,         32'hFFFF_0000, 4'b0100));
    vecs.push_back(alu_v(ialu(4'h3), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100));
    vecs.push_back(alu_v(ialu(4'h4), 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000));
    vecs.push_back(alu_v(ialu(4'h5), 32'h1234_5678, 32'h1234_5678, 32'h0,         4'b0001));
    vecs.push_back(alu_v(ialu(4'h6), 32'h1,         32'h3F,        32'h8000_0000, 4'b0100));
    vecs.push_back(alu_v(ialu(4'h7), 32'h8000_0000, 32'h24,        32'h0800_0000, 4'b0000));
    vecs.push_back(alu_v(ialu(4'h9), 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 4'b0100));
    vecs.push_back(alu_v(ialu(4'hF), 32'h0,         32'h5,         32'h0,         4'b0001));
    vecs.push_back(alu_v(ialu(4'h0), 32'hFFFF_FFFF, 32'h1,         32'h0,         4'b1001));
    vecs.push_back(alu_v(ialu(4'h1), 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 4'b1010));
    vecs.push_back(alu_v(iaddi(16'h0001), 32'h7FFF_FFFF, 32'h0,    32'h8000_0000, 4'b0110));
    vecs.push_back(br_v(ibr(4'h5, 4'h0, 16'hFFFE), 16'h0010, 4'b0000, C_BRREL, 1'b1, 16'h000E));
    vecs.push_back(br_v(ibr(4'h6, 4'h1, 16'h1234), 16'h0000, 4'b0001, C_NONE,  1'b0, 16'h0000));
    vecs.push_back(br_v(ibr(4'h4, 4'h1, 16'h1234), 16'h0000, 4'b0001, C_BRABS, 1'b1, 16'h1234));
    vecs.push_back(br_v(ibr(4'h4, 4'h2, 16'h1234), 16'h0000, 4'b0001, C_NONE,  1'b0, 16'h0000));
    vecs.push_back(br_v(ibr(4'h7, 4'h0, 16'h0040), 16'h0100, 4'b1111, C_NONE,  1'b0, 16'h0000));
    vecs.push_back(br_v(ibr(4'h7, 4'h8, 16'h0020), 16'hFFF0, 4'b0000, C_BRREL, 1'b1, 16'h0010));
    vecs.push_back(br_v(ibr(4'h6, 4'h4, 16'hABCD), 16'h0000, 4'b0000, C_BRABS, 1'b1, 16'hABCD));
    vecs.push_back(br_v(ibr(4'h4, 4'h0, 16'h5555), 16'h0000, 4'b0000, C_BRABS, 1'b1, 16'h5555));
    vecs.push_back(br_v(32'h0000_0000,             16'h0000, 4'b1111, C_NONE,  1'b0, 16'h0000));
    vecs.push_back(br_v(32'h3F00_0001,             16'h0000, 4'b1111, C_NONE,  1'b0, 16'h0000));
    vecs.push_back(br_v(32'h8100_0000,             16'h0000, 4'b1111, C_NONE,  1'b0, 16'h0000));

    // Power-on reset: RESET is entered asynchronously, before any clock edge.
    #1 rst_f = 1'b0;
    #1 chk("reset_async", 32'(ctl()), 32'(C_RST));
    repeat (2) @(negedge clk);
    chk("reset_held", 32'(ctl()), 32'(C_RST));
    reset_release("por");

    foreach (vecs[i]) begin
      if (vecs[i].alu) n_alu++;
      run_vec(vecs[i], i);
    end

    // Reset during DECODE of an ADD must suppress both write pulses.
    s0 = stat_cnt;
    w0 = we_cnt;
    wait_fetch();
    instr = ialu(4'h0); rsa = 32'h1; rsb = 32'h1;
    @(negedge clk);
    #2 rst_f = 1'b0;
    #1 chk("abort_async", 32'(ctl()), 32'(C_RST));
    repeat (3) @(negedge clk);
    chk("abort_held", 32'(ctl()), 32'(C_RST));
    chk("abort_no_stat_en", 32'(stat_cnt), 32'(s0));
    chk("abort_no_rf_we", 32'(we_cnt), 32'(w0));
    reset_release("abort");

    // HLT parks the FSM regardless of later instruction changes.
    wait_fetch();
    instr = 32'hF000_0000;
    @(negedge clk);
    chk("hlt_decode", 32'(ctl()), 32'(C_NONE));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 1) instr = ialu(4'h0);
      chk($sformatf("halt_cycle%0d", k), 32'(ctl()), 32'(C_HALT));
    end
    #2 rst_f = 1'b0;
    #1 chk("halt_rst_async", 32'(ctl()), 32'(C_RST));
    reset_release("halt");

    run_vec(vecs[0], 99);
    @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("stat_en_pulses", 32'(stat_cnt), 32'(n_alu + 1));
    chk("rf_we_pulses", 32'(we_cnt), 32'(n_alu + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
